param_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO: storage, pointer logic and status in one block.

---
 rtl/param_sync_fifo.sv | 110 +++++++++++
 tb/tb_param_sync_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy/threshold flags, error pulses, flush,
// and a choice of first-word-fall-through or registered read port.
module param_sync_fifo #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = 252,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_AF  = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] C_AE  = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] C_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_overflow;
  logic              r_underflow;

  logic [ADDR_W:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Status comes only from the registered pointers, never from the request inputs.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_wr_ok = i_wr_en && !w_full;
  assign w_rd_ok = i_rd_en && !w_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + C_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + C_ONE;
      r_overflow  <= i_wr_en && w_full;
      r_underflow <= i_rd_en && w_empty;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define valid contents.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_flush) r_mem[r_wptr[ADDR_W-1:0]] <= i_wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Drive zero while empty so the port never exposes stale storage.
      assign o_rd_data  = w_empty ? '0 : r_mem[r_rptr[ADDR_W-1:0]];
      assign o_rd_valid = !w_empty;
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (i_flush) begin
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_ok;
          if (w_rd_ok) r_rd_data <= r_mem[r_rptr[ADDR_W-1:0]];
        end
      end

      assign o_rd_data  = r_rd_data;
      assign o_rd_valid = r_rd_valid;
    end
  endgenerate

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_count >= C_AF);
  assign o_almost_empty = (w_count <= C_AE);
  assign o_count        = w_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench: a queue-based FIFO model drives expectations for an FWFT and a
// registered-read instance fed with identical directed and random traffic.
module tb_param_sync_fifo;

  localparam int DW = 4, AW = 3, DEPTH = 8, AF = 6, AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data,  rd_data0;
  logic          rd_valid, rd_valid0;
  logic          full, empty, afull, aempty, ovf, unf;
  logic          full0, empty0, afull0, aempty0, ovf0, unf0;
  logic [AW:0]   count, count0;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  logic [DW-1:0] q[$];      // model contents, head at index 0
  logic [DW-1:0] rdq0[$];   // words the registered port must present next cycle
  bit e_ovf = 1'b0, e_unf = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_full(full),
    .o_empty(empty), .o_almost_full(afull), .o_almost_empty(aempty), .o_count(count),
    .o_overflow(ovf), .o_underflow(unf));

  param_sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(rd_data0), .o_rd_valid(rd_valid0), .o_full(full0),
    .o_empty(empty0), .o_almost_full(afull0), .o_almost_empty(aempty0), .o_count(count0),
    .o_overflow(ovf0), .o_underflow(unf0));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue with the FIFO's acceptance rules.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (flush) begin
        q.delete();
        e_ovf = 1'b0;
        e_unf = 1'b0;
      end else begin
        automatic bit m_full  = (q.size() == DEPTH);
        automatic bit m_empty = (q.size() == 0);
        if (rd_en && !m_empty) rdq0.push_back(q.pop_front());
        if (wr_en && !m_full)  q.push_back(wr_data);
        e_ovf = wr_en && m_full;
        e_unf = rd_en && m_empty;
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    rdq0.delete();
    e_ovf = 1'b0;
    e_unf = 1'b0;
  end

  // Monitor: compares DUT status and presented data against the model each cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en) begin
      chk("count",        int'(count),  q.size());
      chk("full",         int'(full),   int'(q.size() == DEPTH));
      chk("empty",        int'(empty),  int'(q.size() == 0));
      chk("almost_full",  int'(afull),  int'(q.size() >= AF));
      chk("almost_empty", int'(aempty), int'(q.size() <= AE));
      chk("overflow",     int'(ovf),    int'(e_ovf));
      chk("underflow",    int'(unf),    int'(e_unf));
      chk("rd_valid",     int'(rd_valid), int'(q.size() != 0));
      if (rd_valid && q.size() != 0) chk("rd_data", int'(rd_data), int'(q[0]));
      chk("count_reg",    int'(count0), q.size());
      chk("overflow_reg", int'(ovf0),   int'(e_ovf));
      chk("rd_valid_reg", int'(rd_valid0), int'(rdq0.size() != 0));
      if (rdq0.size() != 0) begin
        automatic logic [DW-1:0] exp_w = rdq0.pop_front();
        if (rd_valid0) chk("rd_data_reg", int'(rd_data0), int'(exp_w));
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    @(negedge clk); #1;
    wr_en = w; rd_en = r; flush = f; wr_data = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},     int'(count),     0);
    chk({tag, "_empty"},     int'(empty),     1);
    chk({tag, "_aempty"},    int'(aempty),    1);
    chk({tag, "_full"},      int'(full),      0);
    chk({tag, "_afull"},     int'(afull),     0);
    chk({tag, "_ovf"},       int'(ovf),       0);
    chk({tag, "_unf"},       int'(unf),       0);
    chk({tag, "_rd_valid"},  int'(rd_valid),  0);
    chk({tag, "_rd_data"},   int'(rd_data),   0);
    chk({tag, "_count0"},    int'(count0),    0);
    chk({tag, "_rd_valid0"}, int'(rd_valid0), 0);
    chk({tag, "_rd_data0"},  int'(rd_data0),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 1; i <= 8; i++) drive(1, 0, 0, DW'(i));      // fill to full
    drive(1, 0, 0, 4'hF);                                      // overflow
    for (int i = 0; i < 8; i++) drive(0, 1, 0, '0);           // drain in order
    drive(0, 1, 0, '0);                                        // underflow
    drive(0, 0, 0, '0);

    for (int i = 0; i < 4; i++) drive(1, 0, 0, DW'($urandom));
    for (int i = 0; i < 20; i++) drive(1, 1, 0, DW'($urandom)); // steady count, wrap
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0);

    drive(1, 0, 0, 4'hA);
    drive(0, 1, 0, '0);
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);

    for (int i = 0; i < 5; i++) drive(1, 0, 0, DW'($urandom));
    drive(1, 0, 1, 4'h3);                                      // flush beats write
    drive(0, 0, 0, '0);
    @(negedge clk); #2;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);

    for (int i = 0; i < 3; i++) drive(1, 0, 0, DW'($urandom));
    drive(1, 1, 0, 4'h7);
    @(negedge clk); #3;
    rst_n = 1'b0;                                              // mid-burst reset
    #1;
    check_reset_outputs("async_rst");
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;

    for (int ph = 0; ph < 6; ph++) begin
      automatic int p_wr = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
      for (int i = 0; i < 80; i++)
        drive($urandom_range(99) < p_wr, $urandom_range(99) < (100 - p_wr),
              $urandom_range(59) == 0, DW'($urandom));
    end
    drive(0, 0, 0, '0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
